// File: rtl/or1k_nop_trap_pkg.sv
// Shared constants for the l.nop service-trap side channel: opcode prefix,
// service codes and FSM state encoding.
package or1k_nop_pkg;

   localparam logic [15:0] NOP_PREFIX  = 16'h1500;
   localparam logic [15:0] NOP_EXIT    = 16'h0001;
   localparam logic [15:0] NOP_REPORT  = 16'h0002;
   localparam logic [15:0] NOP_PUTC    = 16'h0004;
   localparam logic [15:0] NOP_CNT_CLR = 16'h0005;

   typedef enum logic {
      RUN    = 1'b0,
      EXITED = 1'b1
   } state_e;

   function automatic logic is_nop_trap(input logic [31:0] insn);
      return insn[31:16] == NOP_PREFIX;
   endfunction

endpackage

// File: rtl/or1k_nop_trap_if.sv
// Retired-instruction input, trap results and console character handshake
// between the writeback stage / console sink and the nop trap block.
interface or1k_nop_trap_if #(
   parameter int CNT_W = 64
);
   logic             insn_valid_i;
   logic [31:0]      insn_i;
   logic [31:0]      r3_i;
   logic             exit_o;
   logic [31:0]      exit_code_o;
   logic             report_valid_o;
   logic [31:0]      report_data_o;
   logic             char_valid_o;
   logic [7:0]       char_o;
   logic             char_ready_i;
   logic             char_overflow_o;
   logic [CNT_W-1:0] retired_cnt_o;

   modport master (
      output insn_valid_i, insn_i, r3_i, char_ready_i,
      input  exit_o, exit_code_o, report_valid_o, report_data_o,
             char_valid_o, char_o, char_overflow_o, retired_cnt_o
   );

   modport slave (
      input  insn_valid_i, insn_i, r3_i, char_ready_i,
      output exit_o, exit_code_o, report_valid_o, report_data_o,
             char_valid_o, char_o, char_overflow_o, retired_cnt_o
   );
endinterface

// File: rtl/or1k_nop_trap_char_fifo.sv
// Synchronous register-array FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate count.
module nop_char_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same edge, so a full FIFO can still accept.
   assign do_push = push && (!full || do_pop);
   // Contents are never reset; gating on empty keeps the head at zero instead.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end
endmodule

// File: rtl/or1k_nop_trap.sv
// Decodes l.nop service traps from the retired-instruction stream into exit,
// report and console-character side channels, and counts retirements.
module or1k_nop_trap
   import or1k_nop_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   or1k_nop_trap_if.slave bus
);
   state_e           state;
   logic             exit_q;
   logic [31:0]      exit_code_q;
   logic             report_vld_q;
   logic [31:0]      report_data_q;
   logic             overflow_q;
   logic [CNT_W-1:0] cnt_q;

   logic             is_trap;
   logic [15:0]      k;
   logic             act;
   logic             do_exit;
   logic             do_report;
   logic             do_putc;
   logic             do_clr;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;

   // Once EXITED, retirements are ignored completely; only reset leaves it.
   assign is_trap   = is_nop_trap(bus.insn_i);
   assign k         = bus.insn_i[15:0];
   assign act       = bus.insn_valid_i && (state == RUN);
   assign do_exit   = act && is_trap && (k == NOP_EXIT);
   assign do_report = act && is_trap && (k == NOP_REPORT);
   assign do_putc   = act && is_trap && (k == NOP_PUTC);
   assign do_clr    = act && is_trap && (k == NOP_CNT_CLR);

   nop_char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (do_putc),
      .din   (bus.r3_i[7:0]),
      .full  (fifo_full),
      .pop   (bus.char_ready_i),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= RUN;
         exit_q        <= 1'b0;
         exit_code_q   <= '0;
         report_vld_q  <= 1'b0;
         report_data_q <= '0;
         overflow_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         report_vld_q <= do_report;
         if (do_report) report_data_q <= bus.r3_i;
         if (do_exit) begin
            state       <= EXITED;
            exit_q      <= 1'b1;
            exit_code_q <= bus.r3_i;
         end
         // The clearing instruction itself is not counted.
         if (act) cnt_q <= do_clr ? '0 : cnt_q + CNT_W'(1);
         if (do_putc && fifo_full && !bus.char_ready_i) overflow_q <= 1'b1;
      end
   end

   assign bus.exit_o          = exit_q;
   assign bus.exit_code_o     = exit_code_q;
   assign bus.report_valid_o  = report_vld_q;
   assign bus.report_data_o   = report_data_q;
   assign bus.char_valid_o    = !fifo_empty;
   assign bus.char_o          = fifo_dout;
   assign bus.char_overflow_o = overflow_q;
   assign bus.retired_cnt_o   = cnt_q;
endmodule

// File: tb/tb_or1k_nop_trap.sv
// Self-checking bench for or1k_nop_trap: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_or1k_nop_trap;
   localparam int DEPTH = 16;
   localparam logic [31:0] ORD = 32'h9C210004;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   or1k_nop_trap_if #(.CNT_W(64)) bus ();

   or1k_nop_trap #(.FIFO_DEPTH(DEPTH), .CNT_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   longint unsigned m_cnt = 0;
   bit              m_exited = 0;
   logic [31:0]     m_code = '0;
   bit              m_rvld = 0;
   logic [31:0]     m_rdata = '0;
   bit              m_ovf = 0;
   logic [7:0]      q[$];

   function automatic logic [31:0] nop(input int code);
      return {16'h1500, code[15:0]};
   endfunction

   task automatic model_update(input logic v, input logic [31:0] insn,
                               input logic [31:0] r3, input logic rdy);
      logic [7:0] dummy;
      if (!rst_n) begin
         m_cnt = 0; m_exited = 0; m_code = '0; m_rvld = 0;
         m_rdata = '0; m_ovf = 0; q.delete();
      end else begin
         m_rvld = 0;
         if (q.size() > 0 && rdy) dummy = q.pop_front();
         if (v && !m_exited) begin
            if (insn[31:16] == 16'h1500 && insn[15:0] == 16'd5) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (insn[31:16] == 16'h1500) begin
               case (insn[15:0])
                  16'd1: begin m_exited = 1; m_code = r3; end
                  16'd2: begin m_rvld = 1; m_rdata = r3; end
                  16'd4: begin
                     if (q.size() < DEPTH) q.push_back(r3[7:0]);
                     else m_ovf = 1;
                  end
                  default: ;
               endcase
            end
         end
      end
   endtask

   task automatic tick(input logic v, input logic [31:0] insn,
                       input logic [31:0] r3, input logic rdy);
      bus.insn_valid_i = v;
      bus.insn_i       = insn;
      bus.r3_i         = r3;
      bus.char_ready_i = rdy;
      @(posedge clk);
      model_update(v, insn, r3, rdy);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(0, '0, '0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 8;
      if (bus.exit_o !== 1'b0) begin failures++; $display("FAIL rst_exit got=%0h exp=0", bus.exit_o); end
      if (bus.exit_code_o !== 32'h0) begin failures++; $display("FAIL rst_exit_code got=%0h exp=0", bus.exit_code_o); end
      if (bus.report_valid_o !== 1'b0) begin failures++; $display("FAIL rst_report_valid got=%0h exp=0", bus.report_valid_o); end
      if (bus.report_data_o !== 32'h0) begin failures++; $display("FAIL rst_report_data got=%0h exp=0", bus.report_data_o); end
      if (bus.char_valid_o !== 1'b0) begin failures++; $display("FAIL rst_char_valid got=%0h exp=0", bus.char_valid_o); end
      if (bus.char_o !== 8'h0) begin failures++; $display("FAIL rst_char got=%0h exp=0", bus.char_o); end
      if (bus.char_overflow_o !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0h exp=0", bus.char_overflow_o); end
      if (bus.retired_cnt_o !== 64'h0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", bus.retired_cnt_o); end
   endtask

   task automatic test_exit();
      do_reset();
      for (int i = 0; i < 10; i++) tick(1, ORD, $urandom, 0);
      checks += 2;
      if (bus.exit_o !== 1'b0) begin failures++; $display("FAIL exit_early got=%0h exp=0", bus.exit_o); end
      if (bus.retired_cnt_o !== 64'd10) begin failures++; $display("FAIL cnt_10 got=%0d exp=10", bus.retired_cnt_o); end
      tick(1, nop(1), 32'h0000002A, 0);
      checks += 3;
      if (bus.exit_o !== 1'b1) begin failures++; $display("FAIL exit_rise got=%0h exp=1", bus.exit_o); end
      if (bus.exit_code_o !== 32'h2A) begin failures++; $display("FAIL exit_code got=%0h exp=2a", bus.exit_code_o); end
      if (bus.retired_cnt_o !== 64'd11) begin failures++; $display("FAIL cnt_11 got=%0d exp=11", bus.retired_cnt_o); end
      tick(1, nop(2), 32'h55, 0);
      checks++;
      if (bus.report_valid_o !== 1'b0) begin failures++; $display("FAIL exited_report got=%0h exp=0", bus.report_valid_o); end
      tick(1, nop(4), 32'h41, 0);
      tick(1, nop(5), 32'h0, 0);
      tick(1, nop(1), 32'h99, 0);
      tick(1, ORD, 32'h0, 0);
      checks += 4;
      if (bus.retired_cnt_o !== 64'd11) begin failures++; $display("FAIL exited_cnt got=%0d exp=11", bus.retired_cnt_o); end
      if (bus.exit_o !== 1'b1) begin failures++; $display("FAIL exit_sticky got=%0h exp=1", bus.exit_o); end
      if (bus.exit_code_o !== 32'h2A) begin failures++; $display("FAIL exit_code_hold got=%0h exp=2a", bus.exit_code_o); end
      if (bus.char_valid_o !== 1'b0) begin failures++; $display("FAIL exited_putc got=%0h exp=0", bus.char_valid_o); end
   endtask

   task automatic test_report();
      do_reset();
      tick(1, nop(2), 32'hDEADBEEF, 0);
      checks += 2;
      if (bus.report_valid_o !== 1'b1) begin failures++; $display("FAIL rep1_valid got=%0h exp=1", bus.report_valid_o); end
      if (bus.report_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rep1_data got=%0h exp=deadbeef", bus.report_data_o); end
      tick(1, nop(2), 32'h12345678, 0);
      checks += 2;
      if (bus.report_valid_o !== 1'b1) begin failures++; $display("FAIL rep2_valid got=%0h exp=1", bus.report_valid_o); end
      if (bus.report_data_o !== 32'h12345678) begin failures++; $display("FAIL rep2_data got=%0h exp=12345678", bus.report_data_o); end
      tick(0, '0, '0, 0);
      checks += 3;
      if (bus.report_valid_o !== 1'b0) begin failures++; $display("FAIL rep_end got=%0h exp=0", bus.report_valid_o); end
      if (bus.report_data_o !== 32'h12345678) begin failures++; $display("FAIL rep_hold got=%0h exp=12345678", bus.report_data_o); end
      if (bus.exit_o !== 1'b0) begin failures++; $display("FAIL rep_exit got=%0h exp=0", bus.exit_o); end
   endtask

   task automatic test_putc();
      do_reset();
      tick(1, nop(4), 32'h48, 1);
      checks += 2;
      if (bus.char_valid_o !== 1'b1) begin failures++; $display("FAIL putc_h_valid got=%0h exp=1", bus.char_valid_o); end
      if (bus.char_o !== 8'h48) begin failures++; $display("FAIL putc_h got=%0h exp=48", bus.char_o); end
      tick(1, nop(4), 32'h69, 1);
      checks += 2;
      if (bus.char_valid_o !== 1'b1) begin failures++; $display("FAIL putc_i_valid got=%0h exp=1", bus.char_valid_o); end
      if (bus.char_o !== 8'h69) begin failures++; $display("FAIL putc_i got=%0h exp=69", bus.char_o); end
      tick(0, '0, '0, 1);
      checks += 2;
      if (bus.char_valid_o !== 1'b0) begin failures++; $display("FAIL putc_drained got=%0h exp=0", bus.char_valid_o); end
      if (bus.char_overflow_o !== 1'b0) begin failures++; $display("FAIL putc_ovf got=%0h exp=0", bus.char_overflow_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) tick(1, nop(4), 32'h41 + i, 0);
      tick(0, '0, '0, 0);
      checks += 2;
      if (bus.char_overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0h exp=1", bus.char_overflow_o); end
      if (bus.char_o !== 8'h41) begin failures++; $display("FAIL ovf_head_stable got=%0h exp=41", bus.char_o); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (bus.char_valid_o !== 1'b1 || bus.char_o !== 8'(8'h41 + i)) begin
            failures++;
            $display("FAIL ovf_drain%0d got=%0h/%0h exp=1/%0h", i, bus.char_valid_o, bus.char_o, 8'(8'h41 + i));
         end
         tick(0, '0, '0, 1);
      end
      checks += 2;
      if (bus.char_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0h exp=0", bus.char_valid_o); end
      if (bus.char_overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", bus.char_overflow_o); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [7:0] last;
      do_reset();
      for (int i = 0; i < 16; i++) tick(1, nop(4), 32'h41 + i, 0);
      tick(1, nop(4), 32'h7A, 1);
      checks++;
      if (bus.char_overflow_o !== 1'b0) begin failures++; $display("FAIL full_pushpop_ovf got=%0h exp=0", bus.char_overflow_o); end
      n = 0;
      last = '0;
      while (bus.char_valid_o === 1'b1 && n < 40) begin
         last = bus.char_o;
         n++;
         tick(0, '0, '0, 1);
      end
      checks += 2;
      if (n != 16) begin failures++; $display("FAIL full_pushpop_count got=%0d exp=16", n); end
      if (last !== 8'h7A) begin failures++; $display("FAIL full_pushpop_last got=%0h exp=7a", last); end
   endtask

   task automatic test_cnt_clr_and_reset();
      do_reset();
      for (int i = 0; i < 300; i++) tick(1, ORD, '0, 0);
      checks++;
      if (bus.retired_cnt_o !== 64'd300) begin failures++; $display("FAIL cnt_300 got=%0d exp=300", bus.retired_cnt_o); end
      tick(1, nop(5), '0, 0);
      checks++;
      if (bus.retired_cnt_o !== 64'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", bus.retired_cnt_o); end
      for (int i = 0; i < 3; i++) tick(1, ORD, '0, 0);
      checks++;
      if (bus.retired_cnt_o !== 64'd3) begin failures++; $display("FAIL cnt_3 got=%0d exp=3", bus.retired_cnt_o); end
      tick(1, nop(4), 32'h33, 0);
      tick(1, nop(1), 32'h7, 0);
      checks += 2;
      if (bus.char_valid_o !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%0h exp=1", bus.char_valid_o); end
      if (bus.exit_o !== 1'b1) begin failures++; $display("FAIL pre_rst_exit got=%0h exp=1", bus.exit_o); end
      test_reset();
   endtask

   task automatic test_random();
      logic        v, rdy;
      logic [31:0] insn, r3;
      int          sel;
      int          codes[9] = '{0, 2, 3, 4, 4, 4, 5, 6, 16'hFFFF};
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         v     = ($urandom_range(0, 3) != 0);
         rdy   = $urandom_range(0, 1);
         r3    = $urandom;
         sel   = $urandom_range(0, 99);
         if (sel < 50) insn = $urandom;
         else if ($urandom_range(0, 199) == 0) insn = nop(1);
         else insn = nop(codes[$urandom_range(0, 8)]);
         tick(v, insn, r3, rdy);
         checks += 8;
         if (bus.exit_o !== m_exited) begin failures++; $display("FAIL rnd_exit c=%0d got=%0h exp=%0h", c, bus.exit_o, m_exited); end
         if (bus.exit_code_o !== m_code) begin failures++; $display("FAIL rnd_exit_code c=%0d got=%0h exp=%0h", c, bus.exit_code_o, m_code); end
         if (bus.report_valid_o !== m_rvld) begin failures++; $display("FAIL rnd_report_valid c=%0d got=%0h exp=%0h", c, bus.report_valid_o, m_rvld); end
         if (bus.report_data_o !== m_rdata) begin failures++; $display("FAIL rnd_report_data c=%0d got=%0h exp=%0h", c, bus.report_data_o, m_rdata); end
         if (bus.char_valid_o !== (q.size() > 0)) begin failures++; $display("FAIL rnd_char_valid c=%0d got=%0h exp=%0h", c, bus.char_valid_o, q.size() > 0); end
         if (bus.char_o !== ((q.size() > 0) ? q[0] : 8'h00)) begin failures++; $display("FAIL rnd_char c=%0d got=%0h exp=%0h", c, bus.char_o, (q.size() > 0) ? q[0] : 8'h00); end
         if (bus.char_overflow_o !== m_ovf) begin failures++; $display("FAIL rnd_overflow c=%0d got=%0h exp=%0h", c, bus.char_overflow_o, m_ovf); end
         if (bus.retired_cnt_o !== m_cnt) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.retired_cnt_o, m_cnt); end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      bus.insn_valid_i = 1'b0;
      bus.insn_i       = '0;
      bus.r3_i         = '0;
      bus.char_ready_i = 1'b0;
      test_reset();
      test_exit();
      test_report();
      test_putc();
      test_overflow();
      test_back_to_back();
      test_cnt_clr_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
